csa_accum_ctrl: RTL and testbench
=================================

CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

Interface
REQ-001 The module SHALL have parameter W, default 16, meaning operand width in bits.
REQ-002 The module SHALL have parameter CW, default 8, meaning operand-count width; the result width is RW = W+CW.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-006 The module SHALL have port len, input, CW bits: number of operands in the frame, captured with start.
REQ-007 The module SHALL have port in_valid, input, 1 bit: operand valid.
REQ-008 The module SHALL have port in_data, input, W bits: unsigned operand.
REQ-009 The module SHALL have port in_ready, output, 1 bit: operand accepted when in_valid and in_ready are both high at a clock edge.
REQ-010 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The module SHALL have port out_sum, output, RW bits: unsigned frame sum.
REQ-012 The module SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high at a clock edge.
REQ-013 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, ACCUM, RESOLVE and DONE.
REQ-015 IDLE: start=1 with len!=0 SHALL capture len, clear the redundant accumulator (S=0, C=0) and the accepted-operand count, and go to ACCUM.
REQ-016 IDLE: start=1 with len=0 SHALL clear the accumulator and go directly to RESOLVE, producing out_sum=0.
REQ-017 ACCUM: in_ready SHALL be 1; in_ready SHALL be 0 in all other states.
REQ-018 Each accepted operand SHALL update the accumulator by 3:2 carry-save compression of S, C and zero-extended in_data, with no carry propagation: S' = S^C^x; C' = majority(S,C,x) shifted left one bit; all RW bits wide.
REQ-019 ACCUM SHALL advance the accepted count by one per accepted operand, and SHALL go to RESOLVE on the edge that accepts operand number len.
REQ-020 ACCUM with in_valid=0 SHALL hold all state; there is no timeout.
REQ-021 RESOLVE SHALL last exactly one cycle and register out_sum = S + C (carry-propagate, modulo 2^RW), then go to DONE.
REQ-022 DONE: out_valid SHALL be 1 and out_sum SHALL be held stable until the out_valid/out_ready handshake completes; on that edge the FSM SHALL go to IDLE.
REQ-023 Latency: out_valid SHALL rise exactly 2 cycles after the edge accepting the last operand, with no dependence on out_ready.
REQ-024 start SHALL be ignored while busy=1; len SHALL not be re-captured mid-frame.
REQ-025 Operands presented with in_valid=1 outside ACCUM SHALL not be accepted and SHALL not affect state.
REQ-026 The result SHALL equal the exact sum for all inputs: len <= 2^CW-1 and W-bit operands cannot overflow RW bits.
REQ-027 start in the same cycle as the DONE handshake SHALL be ignored; a new frame SHALL start only from IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately, and without waiting for a clock edge, force state=IDLE, S=0, C=0, count=0, captured len=0, out_sum=0, out_valid=0, in_ready=0 and busy=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame and produce no partial result; after reset release, the first start SHALL behave as from power-up.

Verification
REQ-030 The bench SHALL check: len=4; operands 1, 2, 3, 4 on consecutive cycles -> out_valid 2 cycles after the 4th accept; out_sum=10.
REQ-031 The bench SHALL check: len=255; all operands 0xFFFF -> out_sum=0xFEFF01; no overflow.
REQ-032 The bench SHALL check: len=3 with in_valid gaps and out_ready held low 5 cycles -> out_sum stable and out_valid high throughout; IDLE after the handshake; start pulses while busy ignored.
REQ-033 The bench SHALL check: len=0 -> out_valid 2 cycles after start; out_sum=0.
REQ-034 The bench SHALL check: rst_n pulsed low after 2 of 5 operands -> all outputs 0 asynchronously; a new frame with len=2, operands 7 and 9 -> out_sum=16.
REQ-035 The bench SHALL check: random len and operands over 1000 frames against a reference integer sum, with random in_valid and out_ready stalls.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// Frame accumulator: sums len unsigned operands in carry-save form, then
// resolves S + C with a single carry-propagate add before handing off the result.
module csa_accum_ctrl #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CW-1:0]     len,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [W+CW-1:0]   out_sum,
    input  logic              out_ready,
    output logic              busy
);
    localparam int RW = W + CW;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t        state;
    logic [RW-1:0] s_q, c_q;
    logic [CW-1:0] len_q, cnt_q;
    logic [RW-1:0] x_ext, s_nxt, c_nxt;

    // 3:2 compressor: no carry ripples here, so the per-operand path stays shallow
    assign x_ext = {{CW{1'b0}}, in_data};
    assign s_nxt = s_q ^ c_q ^ x_ext;
    assign c_nxt = ((s_q & c_q) | (s_q & x_ext) | (c_q & x_ext)) << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            out_sum   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_q      <= '0;
                        c_q      <= '0;
                        cnt_q    <= '0;
                        len_q    <= len;
                        busy     <= 1'b1;
                        in_ready <= (len != '0);
                        state    <= (len != '0) ? ACCUM : RESOLVE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        s_q   <= s_nxt;
                        c_q   <= c_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        // len_q is nonzero here, so len_q-1 cannot wrap
                        if (cnt_q == len_q - 1'b1) begin
                            in_ready <= 1'b0;
                            state    <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum   <= s_q + c_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed and random frames; expected sums are queued at stimulus time and
// popped at each output handshake.
module tb_csa_accum_ctrl;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int RW = W + CW;

    typedef logic [W-1:0] op_q_t[$];

    logic          clk, rst_n, start, in_valid, out_ready;
    logic [CW-1:0] len;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, busy;
    logic [RW-1:0] out_sum;

    logic [RW-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    csa_accum_ctrl #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // One frame: start, feed operands with random in_valid gaps, check the
    // 2-cycle latency, optionally stall out_ready, then pop and compare.
    // noise pulses start / in_valid where they must be ignored.
    task automatic do_frame(input op_q_t ops, input int vpct, input int rpct,
                            input int hold, input bit noise);
        logic [RW-1:0] ref_sum;
        int idx, cyc;
        bit acc, done;
        ref_sum = '0;
        foreach (ops[i]) ref_sum += RW'(ops[i]);
        exp_q.push_back(ref_sum);

        if (noise) begin
            in_valid = 1'b1; in_data = '1;
            tick();
            chk("idle_ignore_in", busy, 0);
            in_valid = 1'b0;
        end

        start = 1'b1; len = CW'(ops.size());
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        idx = 0; cyc = 0;
        while (idx < ops.size() && cyc < 5000) begin
            in_valid = ($urandom_range(99) < vpct);
            in_data  = ops[idx];
            if (noise) begin
                start = $urandom_range(1);
                len   = CW'(200);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        chk("all_accepted", idx, ops.size());

        chk("lat_resolve_low", out_valid, 0);
        tick();
        chk("lat_valid_high", out_valid, 1);

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid = noise; in_data = '1; start = noise;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, exp_q[0]);
            tick();
        end
        in_valid = 1'b0;

        done = 1'b0; cyc = 0;
        while (!done && cyc < 5000) begin
            out_ready = ($urandom_range(99) < rpct);
            start = noise;
            if (out_valid && out_ready) begin
                chk("sum", out_sum, exp_q.pop_front());
                done = 1'b1;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0; start = 1'b0;
        chk("handshake_done", done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    initial begin
        op_q_t ops;
        start = 0; len = '0; in_valid = 0; in_data = '0; out_ready = 0;
        rst_n = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        tick();
        rst_n = 1'b1;
        tick();

        ops = {16'd1, 16'd2, 16'd3, 16'd4};
        do_frame(ops, 100, 100, 0, 0);

        ops.delete();
        for (int i = 0; i < 255; i++) ops.push_back(16'hFFFF);
        do_frame(ops, 100, 100, 0, 0);
        chk("max_sum_const", out_sum, 24'hFEFF01);

        ops = {16'd500, 16'd65535, 16'd42};
        do_frame(ops, 50, 100, 5, 1);

        ops.delete();
        do_frame(ops, 100, 100, 0, 0);
        chk("len0_sum", out_sum, 0);

        // abandon a frame mid-way with an asynchronous reset
        start = 1'b1; len = CW'(5);
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'd11;
        tick(); tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, 0);
        #2;
        rst_n = 1'b1;
        tick();
        ops = {16'd7, 16'd9};
        do_frame(ops, 100, 100, 0, 0);
        chk("post_reset_sum", out_sum, 16);

        for (int f = 0; f < 1000; f++) begin
            ops.delete();
            for (int i = 0, n = $urandom_range(31); i < n; i++)
                ops.push_back(W'($urandom()));
            do_frame(ops, 70, 60, 0, 0);
        end
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
